hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Central pipeline-control sequencer for the 5-stage RV32IM core.
- Merges four stall/flush sources into one set of pipeline-register hold/reset strobes with a fixed priority:
  - data-memory stall;
  - multi-cycle M-extension (MUL/DIV) occupancy of EX;
  - branch/jump redirect;
  - load-use hazard.
- Owns a countdown FSM that freezes the front end while a MUL/DIV instruction occupies EX, and inserts bubbles into MEM.

Parameters:
- MUL_CYCLES, 3, EX-stage latency of MUL* ops in cycles (legal range 1..63).
- DIV_CYCLES, 33, EX-stage latency of DIV*/REM* ops in cycles (legal range 1..63).
- PERF_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- LU_HAZ_SIGNAL  in  1  load-use hazard detected for instruction in ID.
- BRANCH_SEL  in  1  branch/jump taken, resolved in EX.
- EX_MULDIV  in  1  instruction in EX is an M-extension op.
- EX_IS_DIV  in  1  qualifies EX_MULDIV: 1 = DIV/DIVU/REM/REMU, 0 = MUL*.
- DMEM_STALL  in  1  data memory not ready; whole pipeline must freeze.
- PC_HOLD  out  1  PC keeps its value.
- IFID_HOLD  out  1  IF/ID register holds.
- IFID_RESET  out  1  IF/ID register loads a bubble.
- IDEX_HOLD  out  1  ID/EX register holds.
- IDEX_RESET  out  1  ID/EX register loads a bubble.
- EXMEM_HOLD  out  1  EX/MEM register holds.
- EXMEM_RESET  out  1  EX/MEM register loads a bubble.
- MULDIV_VALID  out  1  EX MUL/DIV result is final this cycle.
- MULDIV_BUSY  out  1  FSM in BUSY state.
- STALL_CNT  out  PERF_W  saturating count of cycles with PC_HOLD=1.

Behaviour:

State and reset
- Registered state: FSM {IDLE, BUSY}, 6-bit CNT, STALL_CNT.
- RESET_N low forces, asynchronously, IDLE, CNT=0, STALL_CNT=0.
- All strobe outputs are combinational from registered state plus inputs. With all inputs 0 after reset, every output is 0.
- Reset asserted mid-BUSY aborts the op. After release the FSM is IDLE, and a still-high EX_MULDIV restarts a full count.

MUL/DIV latency
- L = EX_IS_DIV ? DIV_CYCLES : MUL_CYCLES.
- MDSTALL (internal) = (IDLE && EX_MULDIV && L>1) || (BUSY && CNT!=0).
- MULDIV_VALID = (IDLE && EX_MULDIV && L==1) || (BUSY && CNT==0).
- IDLE → BUSY when EX_MULDIV && L>1 && !DMEM_STALL; CNT loads L-2.
- BUSY && !DMEM_STALL:
  - if CNT!=0, CNT decrements;
  - if CNT==0, next state is IDLE.
- DMEM_STALL=1 freezes FSM and CNT entirely:
  - no start from IDLE;
  - no decrement;
  - MULDIV_VALID stays asserted if already at CNT==0.
- Net timing: MDSTALL is high for exactly L-1 cycles, and MULDIV_VALID is high in the following cycle.
- Back-to-back MUL/DIV: a new op enters EX the cycle after VALID, and IDLE starts it immediately.
- BUSY with EX_MULDIV=0 and !DMEM_STALL (illegal): return to IDLE next cycle, MULDIV_VALID=0.
- MULDIV_BUSY = (state==BUSY).

Output priority (first matching row wins; unlisted outputs are 0)
1. DMEM_STALL: PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD = 1. No resets; BRANCH_SEL and LU_HAZ_SIGNAL are re-evaluated after the freeze.
2. MDSTALL: PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_RESET = 1. BRANCH_SEL cannot co-occur (EX holds the MUL/DIV op). LU_HAZ_SIGNAL is ignored, since ID is held.
3. BRANCH_SEL: IFID_RESET, IDEX_RESET = 1. Overrides LU_HAZ_SIGNAL, because the ID instruction is squashed.
4. LU_HAZ_SIGNAL: PC_HOLD, IFID_HOLD, IDEX_RESET = 1.

Other rules
- HOLD and RESET for the same register are never both 1.
- STALL_CNT increments by 1 on each rising edge where PC_HOLD=1, and saturates at 2^PERF_W-1.

Test Plan:
- Reset: RESET_N=0 for 2 cycles with random inputs, then release with all inputs 0 → all strobes 0, STALL_CNT=0, MULDIV_BUSY=0.
- MUL: EX_MULDIV=1, EX_IS_DIV=0 at cycle 0 (MUL_CYCLES=3).
  - Cycles 0–1: PC_HOLD=IFID_HOLD=IDEX_HOLD=EXMEM_RESET=1.
  - Cycle 2: MULDIV_VALID=1, all holds 0.
  - STALL_CNT=2.
- DIV with memory stall: DIV starts at cycle 0 (DIV_CYCLES=33); DMEM_STALL=1 on cycles 10–14.
  - Cycles 10–14: EXMEM_HOLD=1, EXMEM_RESET=0, CNT frozen.
  - MULDIV_VALID at cycle 37.
  - STALL_CNT=37.
- Priority: BRANCH_SEL=1 with LU_HAZ_SIGNAL=1 → IFID_RESET=IDEX_RESET=1, PC_HOLD=0. LU_HAZ_SIGNAL alone → PC_HOLD=IFID_HOLD=IDEX_RESET=1, IFID_RESET=0.
- Back-to-back and abort:
  - Two MULs in consecutive EX slots → two stall windows of 2 cycles separated by one VALID cycle.
  - RESET_N pulsed at BUSY cycle 5 of a DIV → IDLE immediately. After release with EX_MULDIV held, a fresh 32-cycle stall follows.
- Saturation: PERF_W=4, 20 consecutive LU_HAZ_SIGNAL cycles → STALL_CNT=15 and stays 15.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-control bundle: hazard/stall sources in, pipeline-register strobes and status out.
interface hazard_stall_controller_if #(
    parameter int unsigned PERF_W = 16
);
    logic              LU_HAZ_SIGNAL;
    logic              BRANCH_SEL;
    logic              EX_MULDIV;
    logic              EX_IS_DIV;
    logic              DMEM_STALL;
    logic              PC_HOLD;
    logic              IFID_HOLD;
    logic              IFID_RESET;
    logic              IDEX_HOLD;
    logic              IDEX_RESET;
    logic              EXMEM_HOLD;
    logic              EXMEM_RESET;
    logic              MULDIV_VALID;
    logic              MULDIV_BUSY;
    logic [PERF_W-1:0] STALL_CNT;

    modport master (
        output LU_HAZ_SIGNAL, BRANCH_SEL, EX_MULDIV, EX_IS_DIV, DMEM_STALL,
        input  PC_HOLD, IFID_HOLD, IFID_RESET, IDEX_HOLD, IDEX_RESET,
               EXMEM_HOLD, EXMEM_RESET, MULDIV_VALID, MULDIV_BUSY, STALL_CNT
    );

    modport slave (
        input  LU_HAZ_SIGNAL, BRANCH_SEL, EX_MULDIV, EX_IS_DIV, DMEM_STALL,
        output PC_HOLD, IFID_HOLD, IFID_RESET, IDEX_HOLD, IDEX_RESET,
               EXMEM_HOLD, EXMEM_RESET, MULDIV_VALID, MULDIV_BUSY, STALL_CNT
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline hold/flush sequencer: merges dmem stall, MUL/DIV occupancy, redirect and load-use
// hazards by fixed priority, and counts front-end stall cycles.
module hazard_stall_controller #(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned PERF_W     = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    hazard_stall_controller_if.slave bus
);
    localparam int unsigned CNT_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   lat;
    logic               lat_multi;
    logic               mdstall;
    logic               muldiv_valid;
    logic               pc_hold;
    logic               ifid_hold;
    logic               ifid_reset;
    logic               idex_hold;
    logic               idex_reset;
    logic               exmem_hold;
    logic               exmem_reset;
    logic [PERF_W-1:0]  stall_cnt;

    assign lat       = bus.EX_IS_DIV ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
    assign lat_multi = (lat > CNT_W'(1));

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; a memory stall freezes the sequencer completely
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!bus.DMEM_STALL) begin
            case (state)
                IDLE: begin
                    if (bus.EX_MULDIV && lat_multi) begin
                        state_nxt = BUSY;
                        cnt_nxt   = lat - CNT_W'(2);
                    end
                end
                BUSY: begin
                    if (!bus.EX_MULDIV || (cnt == '0)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Strobe outputs, highest-priority source first
    always_comb begin
        mdstall      = 1'b0;
        muldiv_valid = 1'b0;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_reset   = 1'b0;
        idex_hold    = 1'b0;
        idex_reset   = 1'b0;
        exmem_hold   = 1'b0;
        exmem_reset  = 1'b0;

        if (state == IDLE) begin
            mdstall      = bus.EX_MULDIV && lat_multi;
            muldiv_valid = bus.EX_MULDIV && !lat_multi;
        end else begin
            mdstall      = (cnt != '0);
            muldiv_valid = (cnt == '0) && bus.EX_MULDIV;
        end

        if (bus.DMEM_STALL) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
        end else if (mdstall) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_reset = 1'b1;
        end else if (bus.BRANCH_SEL) begin
            ifid_reset = 1'b1;
            idex_reset = 1'b1;
        end else if (bus.LU_HAZ_SIGNAL) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_reset = 1'b1;
        end
    end

    // Saturating count of PC-hold cycles
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt <= '0;
        end else if (pc_hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

    assign bus.PC_HOLD      = pc_hold;
    assign bus.IFID_HOLD    = ifid_hold;
    assign bus.IFID_RESET   = ifid_reset;
    assign bus.IDEX_HOLD    = idex_hold;
    assign bus.IDEX_RESET   = idex_reset;
    assign bus.EXMEM_HOLD   = exmem_hold;
    assign bus.EXMEM_RESET  = exmem_reset;
    assign bus.MULDIV_VALID = muldiv_valid;
    assign bus.MULDIV_BUSY  = (state == BUSY);
    assign bus.STALL_CNT    = stall_cnt;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios plus random traffic
// against an op-progress reference model.
module tb_hazard_stall_controller;
    localparam int unsigned MUL_L = 3;
    localparam int unsigned DIV_L = 33;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic lu = 1'b0, br = 1'b0, md = 1'b0, isdiv = 1'b0, dm = 1'b0;

    hazard_stall_controller_if #(.PERF_W(16)) bus ();
    hazard_stall_controller_if #(.PERF_W(4))  bus_s ();

    assign bus.LU_HAZ_SIGNAL   = lu;
    assign bus.BRANCH_SEL      = br;
    assign bus.EX_MULDIV       = md;
    assign bus.EX_IS_DIV       = isdiv;
    assign bus.DMEM_STALL      = dm;
    assign bus_s.LU_HAZ_SIGNAL = lu;
    assign bus_s.BRANCH_SEL    = br;
    assign bus_s.EX_MULDIV     = md;
    assign bus_s.EX_IS_DIV     = isdiv;
    assign bus_s.DMEM_STALL    = dm;

    hazard_stall_controller #(.MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L), .PERF_W(16)) u_dut (
        .CLK(clk), .RESET_N(rst_n), .bus(bus.slave));
    hazard_stall_controller #(.MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L), .PERF_W(4)) u_sat (
        .CLK(clk), .RESET_N(rst_n), .bus(bus_s.slave));

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: how many unfrozen EX cycles the current op has consumed so far
    int pos   = 0;
    int lat_m = 0;
    int c16   = 0;
    int c4    = 0;

    // Values captured at the most recent sample point
    logic s_pc, s_ifh, s_ifr, s_idh, s_idr, s_exh, s_exr, s_val, s_busy;
    logic [31:0] s_cnt;

    task automatic step(input logic r, input logic l, input logic b, input logic m,
                        input logic d, input logic dv);
        int  op_lat;
        logic e_md, e_val, e_pc;
        logic [8:0] exp_v, obs_v;
        @(negedge clk);
        rst_n = r; lu = l; br = b; md = m; dm = d; isdiv = dv;
        if (!r) begin
            pos = 0; c16 = 0; c4 = 0;
        end
        #1;
        op_lat = (pos > 0) ? lat_m : (dv ? DIV_L : MUL_L);
        e_md   = m && (pos < op_lat - 1);
        e_val  = m && (pos == op_lat - 1);
        if (d)         exp_v = 9'b1_1_0_1_0_1_0_0_0;
        else if (e_md) exp_v = 9'b1_1_0_1_0_0_1_0_0;
        else if (b)    exp_v = 9'b0_0_1_0_1_0_0_0_0;
        else if (l)    exp_v = 9'b1_1_0_0_1_0_0_0_0;
        else           exp_v = 9'b0;
        exp_v[1] = e_val;
        exp_v[0] = (pos > 0);
        e_pc     = exp_v[8];
        obs_v = {bus.PC_HOLD, bus.IFID_HOLD, bus.IFID_RESET, bus.IDEX_HOLD, bus.IDEX_RESET,
                 bus.EXMEM_HOLD, bus.EXMEM_RESET, bus.MULDIV_VALID, bus.MULDIV_BUSY};
        {s_pc, s_ifh, s_ifr, s_idh, s_idr, s_exh, s_exr, s_val, s_busy} = obs_v;
        s_cnt = 32'(bus.STALL_CNT);
        check_eq("strobes", 32'(obs_v), 32'(exp_v));
        check_eq("stall_cnt", 32'(bus.STALL_CNT), 32'(c16));
        check_eq("stall_cnt_sat", 32'(bus_s.STALL_CNT), 32'(c4));
        @(posedge clk);
        if (r) begin
            if (e_pc) begin
                if (c16 < 65535) c16++;
                if (c4 < 15) c4++;
            end
            if (!d && m) begin
                if (pos == 0) lat_m = op_lat;
                if (pos == lat_m - 1) pos = 0;
                else pos++;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int first_valid;
        int stalls;
        logic m, dv, l, b, d, r;

        // Reset: everything quiet afterwards
        do_reset();
        check_eq("reset_strobes", 32'({s_pc, s_ifh, s_ifr, s_idh, s_idr, s_exh, s_exr, s_val}), 32'd0);
        check_eq("reset_busy", 32'(s_busy), 32'd0);
        check_eq("reset_cnt", s_cnt, 32'd0);

        // MUL: two stall cycles, then VALID
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check_eq("mul_pc_hold", 32'(s_pc), (c < 2) ? 32'd1 : 32'd0);
            check_eq("mul_exmem_reset", 32'(s_exr), (c < 2) ? 32'd1 : 32'd0);
            check_eq("mul_valid", 32'(s_val), (c == 2) ? 32'd1 : 32'd0);
        end
        #1 check_eq("mul_stall_total", 32'(bus.STALL_CNT), 32'd2);

        // DIV with a 5-cycle memory freeze
        do_reset();
        first_valid = -1;
        for (int c = 0; c < 60 && first_valid < 0; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, (c >= 10 && c <= 14), 1'b1);
            if (c >= 10 && c <= 14)
                check_eq("div_freeze_exmem", 32'({s_exh, s_exr}), 32'b10);
            if (s_val) begin
                first_valid = c;
                check_eq("div_stall_total", s_cnt, 32'd37);
            end
        end
        check_eq("div_valid_cycle", 32'(first_valid), 32'd37);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Priority: redirect beats load-use, then load-use alone
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("prio_branch", 32'({s_pc, s_ifr, s_idr}), 32'b011);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("prio_loaduse", 32'({s_pc, s_ifh, s_idr, s_ifr}), 32'b1110);

        // Back-to-back MULs
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check_eq("b2b_pc_hold", 32'(s_pc), (c % 3 != 2) ? 32'd1 : 32'd0);
            check_eq("b2b_valid", 32'(s_val), (c % 3 == 2) ? 32'd1 : 32'd0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort a DIV with reset, then a fresh full count
        do_reset();
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("abort_busy_before", 32'(s_busy), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("abort_busy", 32'(s_busy), 32'd0);
        stalls = 0;
        first_valid = -1;
        for (int c = 0; c < 45 && first_valid < 0; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            if (s_val) first_valid = c;
            else if (s_pc) stalls++;
        end
        check_eq("abort_restart_stalls", 32'(stalls), 32'd32);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation of the narrow counter
        do_reset();
        for (int c = 0; c < 20; c++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("sat_cnt4", 32'(bus_s.STALL_CNT), 32'd15);
        check_eq("sat_cnt16", 32'(bus.STALL_CNT), 32'd20);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("sat_cnt4_hold", 32'(bus_s.STALL_CNT), 32'd15);

        // Random traffic; an op in flight keeps its EX instruction until it completes
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) != 0);
            if (pos > 0) begin
                m  = 1'b1;
                dv = (lat_m == DIV_L);
            end else begin
                m  = ($urandom_range(0, 3) == 0);
                dv = 1'($urandom);
            end
            l = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 5) == 0);
            step(r, l, b, m, d, dv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
